// File: rtl/digit_entry_pkg.sv
// Shared types and helpers for the debounced digit-entry block:
// FSM state encoding, code constants and one-hot key decoding.
package digit_entry_pkg;

    localparam int unsigned NKEYS  = 10;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned HCNT_W = 8;

    localparam logic [CODE_W-1:0] XS3_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    typedef struct packed {
        logic              vld;
        logic [CODE_W-1:0] digit;
    } key_info_t;

    // Digit index of the set bit; vld only when exactly one bit is set.
    function automatic key_info_t one_hot_to_digit(input logic [NKEYS-1:0] oh);
        key_info_t   r;
        int unsigned ones;
        r    = '0;
        ones = 0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (oh[i]) begin
                ones    = ones + 1;
                r.digit = CODE_W'(i);
            end
        end
        r.vld = (ones == 1);
        return r;
    endfunction

endpackage

// File: rtl/onehot_code_enc.sv
// Combinational one-hot key to 4-bit digit code (excess-3 or 8421 BCD).
module onehot_code_enc
    import digit_entry_pkg::*;
#(
    parameter int unsigned EXCESS3 = 1
) (
    input  logic [9:0] key_i,
    output logic [3:0] code_o,
    output logic       vld_o
);

    key_info_t info;

    always_comb begin
        info   = one_hot_to_digit(key_i);
        code_o = (EXCESS3 != 0) ? info.digit + XS3_OFFSET : info.digit;
        vld_o  = info.vld;
    end

endmodule

// File: rtl/digit_entry_xs3.sv
// Debounced keypad digit entry: accepts a one-hot key held for HOLD edges and
// shifts its code into an NDIG-deep buffer that a consumer drains with take.
module digit_entry_xs3
    import digit_entry_pkg::*;
#(
    parameter int unsigned NDIG    = 4,
    parameter int unsigned EXCESS3 = 1,
    parameter int unsigned HOLD    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [9:0]                  entrada,
    input  logic                        clr,
    input  logic                        take,
    output logic [3:0]                  S,
    output logic [4*NDIG-1:0]           digits,
    output logic [$clog2(NDIG+1)-1:0]   count,
    output logic                        valid,
    output logic                        err
);

    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned CW = $clog2(NDIG + 1);

    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   cnt_q, cnt_d;
    logic [NKEYS-1:0]    pat_q, pat_d;
    logic [3:0]          s_q, s_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [CW-1:0]       count_q, count_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                fire_c;
    logic [3:0]          code_c;
    logic                code_vld_c;
    logic [HCNT_W-1:0]   cnt_inc_c;
    logic                take_eff_c;
    logic [CW-1:0]       base_count_c;
    logic [DW-1:0]       base_digits_c;

    onehot_code_enc #(
        .EXCESS3 (EXCESS3)
    ) u_enc (
        .key_i  (pat_q),
        .code_o (code_c),
        .vld_o  (code_vld_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            s_q      <= '0;
            digits_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            s_q      <= s_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Debounce FSM: fire_c marks the edge on which the hold count completes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        fire_c    = 1'b0;
        cnt_inc_c = cnt_q + HCNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (entrada != '0) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = HCNT_W'(1);
                    pat_d   = entrada;
                end
            end
            ST_DEBOUNCE: begin
                if (entrada == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pat_d   = '0;
                end else if (entrada == pat_q) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == HCNT_W'(HOLD)) begin
                        fire_c  = 1'b1;
                        state_d = ST_HELD;
                    end
                end else begin
                    cnt_d = HCNT_W'(1);
                    pat_d = entrada;
                end
            end
            ST_HELD: begin
                if (entrada == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pat_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pat_d   = '0;
            end
        endcase
        if (clr) begin
            state_d = (entrada != '0) ? ST_HELD : ST_IDLE;
            cnt_d   = '0;
            pat_d   = '0;
        end
    end

    // Buffer update; take is applied before a same-edge acceptance
    always_comb begin
        take_eff_c    = take && valid_q;
        base_count_c  = take_eff_c ? '0 : count_q;
        base_digits_c = take_eff_c ? '0 : digits_q;
        s_d           = s_q;
        digits_d      = base_digits_c;
        count_d       = base_count_c;
        err_d         = 1'b0;
        if (clr) begin
            s_d      = '0;
            digits_d = '0;
            count_d  = '0;
        end else if (fire_c) begin
            if (!code_vld_c || base_count_c == CW'(NDIG)) begin
                err_d = 1'b1;
            end else begin
                for (int i = int'(NDIG) - 1; i > 0; i--) begin
                    digits_d[4*i +: 4] = base_digits_c[4*(i-1) +: 4];
                end
                digits_d[3:0] = code_c;
                s_d           = code_c;
                count_d       = base_count_c + CW'(1);
            end
        end
        valid_d = (count_d == CW'(NDIG));
    end

    assign S      = s_q;
    assign digits = digits_q;
    assign count  = count_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_digit_entry_xs3.sv
// Bench for digit_entry_xs3: two configurations driven in lockstep and checked
// every cycle against a streak/armed behavioural model of key entry.
`timescale 1ns/1ps
module tb_digit_entry_xs3;

    logic       clk;
    logic       rst_n;
    logic [9:0] entrada;
    logic       clr;
    logic       take;

    logic [3:0]  S_a, S_b;
    logic [15:0] dig_a;
    logic [11:0] dig_b;
    logic [2:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic        val_a, val_b, err_a, err_b;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // model state, index 0 = instance A, 1 = instance B
    int         m_S[2];
    int         m_cnt[2];
    int         m_err[2];
    int         m_buf[2][8];
    bit         m_armed[2];
    int         m_run_len[2];
    logic [9:0] m_run_pat[2];

    digit_entry_xs3 #(.NDIG(4), .EXCESS3(1), .HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .clr(clr), .take(take),
        .S(S_a), .digits(dig_a), .count(cnt_a), .valid(val_a), .err(err_a)
    );

    digit_entry_xs3 #(.NDIG(3), .EXCESS3(0), .HOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .clr(clr), .take(take),
        .S(S_b), .digits(dig_b), .count(cnt_b), .valid(val_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ndig_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic int xs3_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic logic [9:0] key(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic logic [31:0] exp_digits(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < ndig_of(k); i++) v[4*i +: 4] = 4'(m_buf[k][i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_S[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
        for (int i = 0; i < 8; i++) m_buf[k][i] = 0;
        m_armed[k] = 1'b1; m_run_len[k] = 0; m_run_pat[k] = '0;
    endtask

    task automatic model_clear_buf(input int k);
        m_cnt[k] = 0;
        for (int i = 0; i < 8; i++) m_buf[k][i] = 0;
    endtask

    // A key counts once it has been seen HOLD edges in a row since the last release.
    task automatic model_edge(input int k, input logic [9:0] e, input logic c, input logic t);
        bit fire;
        int d;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        m_err[k] = 0;
        fire = 1'b0;
        if (c) begin
            model_clear_buf(k);
            m_S[k] = 0;
            m_armed[k] = (e == '0);
            m_run_len[k] = 0;
            return;
        end
        if (t && m_cnt[k] == ndig_of(k)) model_clear_buf(k);
        if (e == '0) begin
            m_armed[k] = 1'b1;
            m_run_len[k] = 0;
        end else if (m_armed[k]) begin
            if (m_run_len[k] > 0 && e == m_run_pat[k]) m_run_len[k]++;
            else begin
                m_run_pat[k] = e;
                m_run_len[k] = 1;
            end
            if (m_run_len[k] == hold_of(k)) begin
                fire = 1'b1;
                m_armed[k] = 1'b0;
                m_run_len[k] = 0;
            end
        end
        if (fire) begin
            if ($countones(e) != 1 || m_cnt[k] == ndig_of(k)) m_err[k] = 1;
            else begin
                d = 0;
                for (int i = 0; i < 10; i++) if (e[i]) d = i;
                for (int i = 7; i > 0; i--) m_buf[k][i] = m_buf[k][i-1];
                m_buf[k][0] = d + xs3_of(k);
                m_S[k] = d + xs3_of(k);
                m_cnt[k]++;
            end
        end
    endtask

    task automatic step(input logic [9:0] e, input logic c, input logic t);
        entrada = e; clr = c; take = t;
        @(posedge clk);
        #1;
        model_edge(0, e, c, t);
        model_edge(1, e, c, t);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int d, input int n);
        repeat (n) step(key(d), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("S_a", 32'(S_a), 32'(m_S[0]));
            chk("digits_a", 32'(dig_a), exp_digits(0));
            chk("count_a", 32'(cnt_a), 32'(m_cnt[0]));
            chk("valid_a", 32'(val_a), 32'(m_cnt[0] == 4));
            chk("err_a", 32'(err_a), 32'(m_err[0]));
            chk("S_b", 32'(S_b), 32'(m_S[1]));
            chk("digits_b", 32'(dig_b), exp_digits(1));
            chk("count_b", 32'(cnt_b), 32'(m_cnt[1]));
            chk("valid_b", 32'(val_b), 32'(m_cnt[1] == 3));
            chk("err_b", 32'(err_b), 32'(m_err[1]));
        end
    end

    initial begin
        logic [9:0] cur;
        int r;
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        rst_n = 1'b0; entrada = '0; clr = 1'b0; take = 1'b0;
        model_reset(0); model_reset(1);
        repeat (2) step('0, 1'b0, 1'b0);
        chk("rst_S", 32'(S_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // digit 3 held exactly HOLD edges
        repeat (4) step(key(3), 1'b0, 1'b0);
        chk("acc_S", 32'(S_a), 32'h6);
        chk("acc_nib0", 32'(dig_a[3:0]), 32'h6);
        chk("acc_count", 32'(cnt_a), 32'd1);
        step('0, 1'b0, 1'b0);

        // short glitch is not accepted
        step('0, 1'b1, 1'b0);
        press(2, 3);
        chk("glitch_count", 32'(cnt_a), 32'd0);
        chk("glitch_S", 32'(S_a), 32'd0);

        // two keys together
        repeat (4) step(10'b0000000011, 1'b0, 1'b0);
        chk("multi_err", 32'(err_a), 32'd1);
        chk("multi_count", 32'(cnt_a), 32'd0);
        step('0, 1'b0, 1'b0);
        chk("multi_err_pulse", 32'(err_a), 32'd0);

        // fill the buffer, overflow, then drain
        press(1, 4); press(2, 4); press(3, 4); press(4, 4);
        chk("full_digits", 32'(dig_a), 32'h4567);
        chk("full_valid", 32'(val_a), 32'd1);
        repeat (4) step(key(9), 1'b0, 1'b0);
        chk("ovf_err", 32'(err_a), 32'd1);
        chk("ovf_digits", 32'(dig_a), 32'h4567);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        chk("take_count", 32'(cnt_a), 32'd0);
        chk("take_valid", 32'(val_a), 32'd0);
        chk("take_S", 32'(S_a), 32'h7);

        // plain BCD instance
        step('0, 1'b1, 1'b0);
        press(9, 2);
        chk("bcd_S9", 32'(S_b), 32'h9);
        press(0, 2);
        chk("bcd_S0", 32'(S_b), 32'h0);
        chk("bcd_count", 32'(cnt_b), 32'd2);

        // reset while debouncing a held key
        press(7, 4);
        repeat (2) step(key(5), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        chk("arst_S", 32'(S_a), 32'd0);
        chk("arst_count", 32'(cnt_a), 32'd0);
        chk("arst_digits", 32'(dig_a), 32'd0);
        repeat (2) step(key(5), 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) step(key(5), 1'b0, 1'b0);
        chk("arst_not_yet", 32'(cnt_a), 32'd0);
        step(key(5), 1'b0, 1'b0);
        chk("arst_accept", 32'(cnt_a), 32'd1);
        chk("arst_accept_S", 32'(S_a), 32'h8);
        step('0, 1'b0, 1'b0);

        // randomized key activity
        cur = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(9) >= 8) begin
                r = $urandom_range(9);
                if (r < 4) cur = '0;
                else if (r < 9) cur = key($urandom_range(9));
                else cur = key($urandom_range(9)) | key($urandom_range(9));
            end
            step(cur, ($urandom_range(39) == 0), ($urandom_range(5) == 0));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_entry_xs3.md
DIGIT_ENTRY_XS3 -- requirements
Module: digit_entry_xs3

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of buffered digits (1..8).
REQ-002 SHALL have parameter EXCESS3, default 1: 1 = excess-3 code (digit+3); 0 = plain 8421 BCD.
REQ-003 SHALL have parameter HOLD, default 4, consecutive sampled edges a key pattern must persist to be accepted (2..255).
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: entrada  in  10  one-hot keys, bit i = digit i.
REQ-007 SHALL have ports: clr  in  1  synchronous buffer clear.
REQ-008 SHALL have ports: take  in  1  consumer acknowledge of a full buffer.
REQ-009 SHALL have ports: S  out  4  code of last accepted digit.
REQ-010 SHALL have ports: digits  out  4*NDIG  buffer, newest digit in bits [3:0].
REQ-011 SHALL have ports: count  out  $clog2(NDIG+1)  digits held.
REQ-012 SHALL have ports: valid  out  1  buffer full, held until take or clr.
REQ-013 SHALL have ports: err  out  1  one-cycle pulse on rejected input.

Function
REQ-014 Code mapping SHALL be digit d -> d+3 (0011..1100) when EXCESS3=1, d (0000..1001) when EXCESS3=0.
REQ-015 FSM SHALL have states IDLE, DEBOUNCE, HELD.
REQ-016 IDLE: entrada==0 stays; any nonzero -> DEBOUNCE, stability counter = 1, pattern latched.
REQ-017 DEBOUNCE: entrada equal to latched pattern increments counter; changed nonzero pattern reloads pattern, counter=1; zero -> IDLE, no error.
REQ-018 Acceptance SHALL occur on the edge where the counter reaches HOLD with a one-hot pattern; FSM -> HELD same edge.
REQ-019 Counter reaching HOLD with a multi-hot pattern SHALL pulse err one cycle, accept nothing, go to HELD.
REQ-020 HELD: stays until entrada==0 for one sampled edge, then IDLE; no repeat acceptance while held.
REQ-021 On acceptance with count<NDIG: S and digits[3:0] = new code, older nibbles shift up one nibble, count+1, all visible the cycle after the accepting edge.
REQ-022 On acceptance with count==NDIG: buffer, S, count unchanged; err pulses one cycle.
REQ-023 valid SHALL be 1 exactly when count==NDIG.
REQ-024 take with valid=1: next edge count=0, digits=0, valid=0; S keeps value. take with valid=0 ignored.
REQ-025 clr: next edge count=0, digits=0, S=0, FSM -> HELD if entrada!=0 else IDLE; clr has priority over acceptance and take.
REQ-026 Acceptance and take on same edge: take applies first, then the digit is stored (count=1).
REQ-027 Empty nibbles SHALL read 0000.

Reset
REQ-028 rst_n low SHALL immediately force S=0, digits=0, count=0, valid=0, err=0, FSM=IDLE, counter=0, pattern=0.
REQ-029 Reset mid-debounce SHALL discard the pending key; a key still pressed after release of rst_n SHALL be debounced from count 1.

Structure
REQ-030 Shared package digit_entry_pkg SHALL hold the FSM state enum, the excess-3 offset constant (3) and a function one_hot_to_digit returning digit and one-hot-valid flag.
REQ-031 One sub-module, onehot_code_enc (combinational 10-bit one-hot -> 4-bit code plus valid, parameter EXCESS3), SHALL be instantiated once.
REQ-032 All state SHALL be in flops on clk; no latches; outputs registered.

Verification
REQ-033 HOLD=4, entrada=0000001000 for 4 edges, then 0 -> S=0110, digits[3:0]=0110, count=1, err never 1.
REQ-034 Glitch: entrada=0000000100 for 3 edges, then 0 -> count stays 0, S stays 0000, no err.
REQ-035 entrada=0000000011 for 4 edges -> err one cycle, count unchanged.
REQ-036 NDIG=4: press 1,2,3,4 -> digits=0100_0101_0110_0111, valid=1; fifth press 9 -> err pulse, digits unchanged; take -> count=0, valid=0.
REQ-037 EXCESS3=0: press 9 -> S=1001; press 0 -> S=0000, count=2.
REQ-038 rst_n low during DEBOUNCE with key held -> outputs 0 immediately; after release, key accepted exactly HOLD edges later.
